// File: rtl/rs232_cmd_pkg.sv
// Shared opcodes, response codes and state encodings for the RS232 command responder.
package rs232_cmd_pkg;

  localparam logic [7:0] OP_WR     = 8'h57;
  localparam logic [7:0] OP_RD     = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BADOP = 8'h3F;
  localparam logic [7:0] RSP_RDTO  = 8'h21;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS_WR,
    BUS_RD,
    WAIT_RD,
    SEND,
    SEND_HOLD
  } state_t;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT,
    HS_HOLD
  } hs_state_t;

endpackage

// File: rtl/rs232_cmd_responder_if.sv
// UART byte streams plus register-bus signals seen by the command responder.
interface rs232_cmd_responder_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       ena_tx;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_we;
  logic       bus_re;
  logic [7:0] bus_rdata;
  logic       bus_rvalid;
  logic       overrun;

  modport master (
    input  rx_rdy, rx_data, tx_busy, bus_rdata, bus_rvalid,
    output ena_tx, tx_data, bus_addr, bus_wdata, bus_we, bus_re, overrun
  );

  modport slave (
    output rx_rdy, rx_data, tx_busy, bus_rdata, bus_rvalid,
    input  ena_tx, tx_data, bus_addr, bus_wdata, bus_we, bus_re, overrun
  );
endinterface

// File: rtl/rs232_tx_handshake.sv
// One-entry transmit request stage: waits for tx_busy low, pulses ena_tx once,
// then holds off one clock until the UART's tx_busy has had time to rise.
module rs232_tx_handshake
  import rs232_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       ready,
  input  logic       tx_busy,
  output logic       ena_tx,
  output logic [7:0] tx_data
);

  hs_state_t  hs_q, hs_d;
  logic       ena_tx_q, ena_tx_d;
  logic [7:0] tx_data_q, tx_data_d;

  always_comb begin
    hs_d      = hs_q;
    ena_tx_d  = 1'b0;
    tx_data_d = tx_data_q;
    unique case (hs_q)
      HS_IDLE: begin
        if (load) begin
          tx_data_d = load_data;
          if (!tx_busy) begin
            ena_tx_d = 1'b1;
            hs_d     = HS_HOLD;
          end else begin
            hs_d = HS_WAIT;
          end
        end
      end
      HS_WAIT: begin
        if (!tx_busy) begin
          ena_tx_d = 1'b1;
          hs_d     = HS_HOLD;
        end
      end
      HS_HOLD: hs_d = HS_IDLE;
      default: hs_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q      <= HS_IDLE;
      ena_tx_q  <= 1'b0;
      tx_data_q <= 8'h00;
    end else begin
      hs_q      <= hs_d;
      ena_tx_q  <= ena_tx_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ready   = (hs_q == HS_IDLE);
  assign ena_tx  = ena_tx_q;
  assign tx_data = tx_data_q;

endmodule

// File: rtl/rs232_cmd_responder.sv
// Decodes 'W' addr data / 'R' addr host commands into register-bus strobes and
// returns one response byte per command through the transmit handshake.
module rs232_cmd_responder
  import rs232_cmd_pkg::*;
#(
  parameter int SYSCLK_MHZ      = 27,
  parameter int BYTE_TIMEOUT_US = 10000,
  parameter int RD_TIMEOUT_CLKS = 255
) (
  input logic                 clk,
  input logic                 reset,
  rs232_cmd_responder_if.master io
);

  localparam logic [31:0] BYTE_LIMIT = 32'(SYSCLK_MHZ * BYTE_TIMEOUT_US);
  localparam int RD_CNT_W = (RD_TIMEOUT_CLKS < 2) ? 1 : $clog2(RD_TIMEOUT_CLKS + 1);
  localparam logic [RD_CNT_W-1:0] RD_LIMIT = RD_CNT_W'(RD_TIMEOUT_CLKS);

  state_t              state_q, state_d;
  logic                is_rd_q, is_rd_d;
  logic [7:0]          bus_addr_q, bus_addr_d;
  logic [7:0]          bus_wdata_q, bus_wdata_d;
  logic [7:0]          resp_q, resp_d;
  logic [31:0]         byte_cnt_q, byte_cnt_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                overrun_q, overrun_d;

  logic                hs_load;
  logic [7:0]          hs_data;
  logic                hs_ready;
  logic                hs_ena_tx;
  logic [7:0]          hs_tx_data;

  always_comb begin
    state_d     = state_q;
    is_rd_d     = is_rd_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    resp_d      = resp_q;
    byte_cnt_d  = byte_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    overrun_d   = overrun_q;
    hs_load     = 1'b0;
    hs_data     = resp_q;

    if (io.rx_rdy && (state_q inside {BUS_WR, BUS_RD, WAIT_RD, SEND, SEND_HOLD}))
      overrun_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (io.rx_rdy) begin
          byte_cnt_d = 32'd0;
          if (io.rx_data == OP_WR) begin
            is_rd_d = 1'b0;
            state_d = GET_ADDR;
          end else if (io.rx_data == OP_RD) begin
            is_rd_d = 1'b1;
            state_d = GET_ADDR;
          end else begin
            resp_d  = RSP_BADOP;
            state_d = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (io.rx_rdy) begin
          bus_addr_d = io.rx_data;
          byte_cnt_d = 32'd0;
          if (is_rd_q) begin
            rd_cnt_d = '0;
            state_d  = BUS_RD;
          end else begin
            state_d = GET_DATA;
          end
        end else if (byte_cnt_q == BYTE_LIMIT) begin
          state_d = IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + 32'd1;
        end
      end
      GET_DATA: begin
        if (io.rx_rdy) begin
          bus_wdata_d = io.rx_data;
          byte_cnt_d  = 32'd0;
          state_d     = BUS_WR;
        end else if (byte_cnt_q == BYTE_LIMIT) begin
          state_d = IDLE;
        end else begin
          byte_cnt_d = byte_cnt_q + 32'd1;
        end
      end
      BUS_WR: begin
        resp_d  = RSP_OK;
        state_d = SEND;
      end
      BUS_RD: begin
        // rd_cnt tracks clocks since bus_re, so it already counts this cycle
        rd_cnt_d = rd_cnt_q + 1'b1;
        state_d  = WAIT_RD;
      end
      WAIT_RD: begin
        // Read replies go straight to the handshake to keep rvalid-to-ena_tx at one clock
        if (io.bus_rvalid) begin
          resp_d  = io.bus_rdata;
          hs_load = 1'b1;
          hs_data = io.bus_rdata;
          state_d = SEND_HOLD;
        end else if (rd_cnt_q == RD_LIMIT) begin
          resp_d  = RSP_RDTO;
          hs_load = 1'b1;
          hs_data = RSP_RDTO;
          state_d = SEND_HOLD;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (hs_ready) begin
          hs_load = 1'b1;
          state_d = SEND_HOLD;
        end
      end
      SEND_HOLD: begin
        if (hs_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      is_rd_q     <= 1'b0;
      bus_addr_q  <= 8'h00;
      bus_wdata_q <= 8'h00;
      resp_q      <= 8'h00;
      byte_cnt_q  <= 32'd0;
      rd_cnt_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_rd_q     <= is_rd_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      resp_q      <= resp_d;
      byte_cnt_q  <= byte_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  rs232_tx_handshake u_tx_hs (
    .clk       (clk),
    .reset     (reset),
    .load      (hs_load),
    .load_data (hs_data),
    .ready     (hs_ready),
    .tx_busy   (io.tx_busy),
    .ena_tx    (hs_ena_tx),
    .tx_data   (hs_tx_data)
  );

  assign io.ena_tx    = hs_ena_tx;
  assign io.tx_data   = hs_tx_data;
  assign io.bus_we    = (state_q == BUS_WR);
  assign io.bus_re    = (state_q == BUS_RD);
  assign io.bus_addr  = bus_addr_q;
  assign io.bus_wdata = bus_wdata_q;
  assign io.overrun   = overrun_q;

endmodule

// File: tb/tb_rs232_cmd_responder.sv
// Directed bench for rs232_cmd_responder: write, read, bad opcode, byte and read
// timeouts, flow control with overrun, and reset mid-operation.
module tb_rs232_cmd_responder;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  rs232_cmd_responder_if u_if ();

  rs232_cmd_responder #(
    .SYSCLK_MHZ      (27),
    .BYTE_TIMEOUT_US (2),
    .RD_TIMEOUT_CLKS (255)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (u_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  int we_cnt = 0, we_cyc = 0;
  int re_cnt = 0, re_cyc = 0;
  int tx_cnt = 0, tx_cyc = 0;
  int rx_cyc = 0;
  int dbl_ena = 0;
  logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, last_tx = 0;
  logic ena_prev = 1'b0;

  always @(negedge clk) begin
    ena_prev <= u_if.ena_tx;
    if (u_if.ena_tx && ena_prev) dbl_ena <= dbl_ena + 1;
    if (u_if.rx_rdy) rx_cyc <= cyc;
    if (u_if.bus_we) begin
      we_cnt <= we_cnt + 1; we_cyc <= cyc;
      we_addr <= u_if.bus_addr; we_data <= u_if.bus_wdata;
    end
    if (u_if.bus_re) begin
      re_cnt <= re_cnt + 1; re_cyc <= cyc; re_addr <= u_if.bus_addr;
    end
    if (u_if.ena_tx) begin
      tx_cnt <= tx_cnt + 1; tx_cyc <= cyc; last_tx <= u_if.tx_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    u_if.rx_rdy = 1'b1; u_if.rx_data = b;
    @(posedge clk); #1;
    u_if.rx_rdy = 1'b0;
  endtask

  // sel 0 waits for a new ena_tx, sel 1 for a new bus_re
  task automatic wait_evt(input string tag, input int sel, input int prev, input int budget);
    int i = 0;
    while ((((sel == 0) ? tx_cnt : re_cnt) == prev) && (i < budget)) begin
      @(negedge clk); #1;
      i++;
    end
    check(tag, (sel == 0) ? tx_cnt : re_cnt, prev + 1);
  endtask

  task automatic pulse_rvalid(input int delay, input logic [7:0] d);
    repeat (delay) @(posedge clk);
    #1;
    u_if.bus_rvalid = 1'b1; u_if.bus_rdata = d;
    @(posedge clk); #1;
    u_if.bus_rvalid = 1'b0;
  endtask

  function automatic logic [31:0] outs();
    return {4'h0, u_if.ena_tx, u_if.bus_we, u_if.bus_re, u_if.overrun,
            u_if.tx_data, u_if.bus_addr, u_if.bus_wdata};
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0, w0, r0, f;
    reset = 1'b1;
    u_if.rx_rdy = 1'b0; u_if.rx_data = 8'h00; u_if.tx_busy = 1'b0;
    u_if.bus_rdata = 8'h00; u_if.bus_rvalid = 1'b0;
    #1;
    check("reset_outputs", outs(), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // Write 0x57 0x10 0xA5
    t0 = tx_cnt;
    send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
    wait_evt("wr_reply_seen", 0, t0, 50);
    check("wr_we_count", we_cnt, 1);
    check("wr_addr", we_addr, 8'h10);
    check("wr_data", we_data, 8'hA5);
    check("wr_byte_to_we", we_cyc - rx_cyc, 1);
    check("wr_we_to_ena", tx_cyc - we_cyc, 2);
    check("wr_reply", last_tx, 8'h4B);
    check("wr_overrun", u_if.overrun, 1'b0);
    repeat (4) @(posedge clk);

    // Read 0x52 0x22, rvalid three clocks after bus_re
    t0 = tx_cnt; r0 = re_cnt;
    send_byte(8'h52); send_byte(8'h22);
    wait_evt("rd_re_seen", 1, r0, 20);
    pulse_rvalid(3, 8'h3C);
    wait_evt("rd_reply_seen", 0, t0, 20);
    check("rd_addr", re_addr, 8'h22);
    check("rd_reply", last_tx, 8'h3C);
    check("rd_rvalid_to_ena", tx_cyc - re_cyc, 4);
    repeat (4) @(posedge clk);

    // Read with no rvalid times out
    t0 = tx_cnt; r0 = re_cnt;
    send_byte(8'h52); send_byte(8'h33);
    wait_evt("rdto_re_seen", 1, r0, 20);
    wait_evt("rdto_reply_seen", 0, t0, 400);
    check("rdto_reply", last_tx, 8'h21);
    check("rdto_latency", tx_cyc - re_cyc, 256);
    repeat (4) @(posedge clk);

    // Stray rvalid while idle produces nothing
    t0 = tx_cnt;
    pulse_rvalid(0, 8'hEE);
    repeat (10) @(posedge clk);
    check("stray_rvalid", tx_cnt, t0);

    // Bad opcode, then a normal read
    t0 = tx_cnt; w0 = we_cnt; r0 = re_cnt;
    send_byte(8'h00);
    wait_evt("bad_reply_seen", 0, t0, 20);
    check("bad_reply", last_tx, 8'h3F);
    check("bad_no_we", we_cnt, w0);
    check("bad_no_re", re_cnt, r0);
    repeat (4) @(posedge clk);
    t0 = tx_cnt;
    send_byte(8'h52); send_byte(8'h01);
    wait_evt("after_bad_re_seen", 1, r0, 20);
    pulse_rvalid(1, 8'h99);
    wait_evt("after_bad_reply_seen", 0, t0, 20);
    check("after_bad_addr", re_addr, 8'h01);
    check("after_bad_reply", last_tx, 8'h99);
    repeat (4) @(posedge clk);

    // Byte timeout in the middle of a write (limit is 54 clocks)
    t0 = tx_cnt; w0 = we_cnt; r0 = re_cnt;
    send_byte(8'h57); send_byte(8'h10);
    repeat (120) @(posedge clk);
    check("bto_silent", tx_cnt, t0);
    send_byte(8'h52); send_byte(8'h05);
    wait_evt("bto_re_seen", 1, r0, 20);
    pulse_rvalid(2, 8'h77);
    wait_evt("bto_reply_seen", 0, t0, 20);
    check("bto_no_we", we_cnt, w0);
    check("bto_rd_addr", re_addr, 8'h05);
    check("bto_reply", last_tx, 8'h77);
    repeat (10) @(posedge clk);
    check("bto_one_reply", tx_cnt, t0 + 1);

    // Flow control: reply held off by tx_busy, rx byte during wait dropped
    t0 = tx_cnt; w0 = we_cnt; r0 = re_cnt;
    u_if.tx_busy = 1'b1;
    send_byte(8'hAA);
    send_byte(8'h57);
    repeat (496) @(posedge clk);
    check("fc_held", tx_cnt, t0);
    check("fc_overrun", u_if.overrun, 1'b1);
    @(posedge clk); #1;
    u_if.tx_busy = 1'b0;
    f = cyc;
    wait_evt("fc_reply_seen", 0, t0, 20);
    check("fc_ena_after_fall", tx_cyc - f, 1);
    check("fc_reply", last_tx, 8'h3F);
    repeat (4) @(posedge clk);
    t0 = tx_cnt;
    send_byte(8'h52); send_byte(8'h07);
    wait_evt("fc_next_re_seen", 1, r0, 20);
    pulse_rvalid(1, 8'h5A);
    wait_evt("fc_next_reply_seen", 0, t0, 20);
    check("fc_next_addr", re_addr, 8'h07);
    check("fc_next_reply", last_tx, 8'h5A);
    check("fc_no_we", we_cnt, w0);
    repeat (4) @(posedge clk);

    // Reset during WAIT_RD
    t0 = tx_cnt; r0 = re_cnt;
    send_byte(8'h52); send_byte(8'h40);
    wait_evt("rstrd_re_seen", 1, r0, 20);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstrd_outputs", outs(), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(posedge clk);
    check("rstrd_no_reply", tx_cnt, t0);
    check("rstrd_no_re", re_cnt, r0 + 1);

    // Reset during SEND while the UART is busy
    t0 = tx_cnt;
    u_if.tx_busy = 1'b1;
    send_byte(8'h00);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstsend_outputs", outs(), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    u_if.tx_busy = 1'b0;
    repeat (50) @(posedge clk);
    check("rstsend_no_reply", tx_cnt, t0);

    // Write after recovery
    t0 = tx_cnt; w0 = we_cnt;
    send_byte(8'h57); send_byte(8'h80); send_byte(8'h01);
    wait_evt("rec_reply_seen", 0, t0, 50);
    check("rec_we_count", we_cnt, w0 + 1);
    check("rec_addr", we_addr, 8'h80);
    check("rec_reply", last_tx, 8'h4B);
    check("ena_never_back_to_back", dbl_ena, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs232_cmd_responder.md
Name: rs232_cmd_responder

Overview:
- Command responder on the host-facing RS232 link: consumes the received byte stream (rx_rdy/rx_data) and drives the transmit request port (ena_tx/tx_data/tx_busy) of the sync UART.
- Decodes 2- and 3-byte host commands into single-cycle register-bus read/write strobes and returns one response byte per command.
- Sits between the UART and the GPIO/screen register file.
- One command is outstanding at a time.

Parameters:
- SYSCLK_MHZ, 27: system clock in MHz. Used only for timeout scaling.
- BYTE_TIMEOUT_US, 10000: maximum gap between bytes of one command, in µs. The limit is SYSCLK_MHZ*BYTE_TIMEOUT_US clocks, held in a 32-bit counter.
- RD_TIMEOUT_CLKS, 255: maximum wait for bus_rvalid after bus_re, in clocks.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_rdy  in  1  one-clock pulse, rx_data valid
- rx_data  in  8  received byte
- ena_tx  out  1  one-clock request to UART to latch tx_data
- tx_data  out  8  byte to transmit
- tx_busy  in  1  UART transmit holding register occupied
- bus_addr  out  8  register address
- bus_wdata  out  8  write data
- bus_we  out  1  one-clock write strobe
- bus_re  out  1  one-clock read strobe
- bus_rdata  in  8  read data, valid with bus_rvalid
- bus_rvalid  in  1  read data valid pulse
- overrun  out  1  sticky flag: an rx byte was discarded

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0: ena_tx, bus_we, bus_re, overrun, tx_data, bus_addr, bus_wdata. Counters are 0.
- Command protocol:
  - 0x57 'W', addr, data -> write, reply 0x4B 'K'.
  - 0x52 'R', addr -> read, reply the read data byte.
  - Any other first byte -> reply 0x3F '?' and return to IDLE.
- State machine:
  - IDLE: on rx_rdy, 'W' -> GET_ADDR(wr); 'R' -> GET_ADDR(rd); else load resp=0x3F and go to SEND.
  - GET_ADDR: on rx_rdy, latch bus_addr. For a write go to GET_DATA; for a read go to BUS_RD.
  - GET_DATA: on rx_rdy, latch bus_wdata and go to BUS_WR.
  - BUS_WR: bus_we=1 for exactly one clock; resp=0x4B; go to SEND.
  - BUS_RD: bus_re=1 for exactly one clock; clear the read counter; go to WAIT_RD.
  - WAIT_RD: if bus_rvalid, resp=bus_rdata and go to SEND. Else, if the counter equals RD_TIMEOUT_CLKS, resp=0x21 '!' and go to SEND. Else the counter increments.
  - SEND: wait for tx_busy==0. Then tx_data=resp and ena_tx=1 for one clock; go to SEND_HOLD.
  - SEND_HOLD: one-clock guard, because the UART's tx_busy rises the clock after ena_tx. Return to IDLE. ena_tx must never be high on two consecutive clocks.
- Byte timeout (GET_ADDR/GET_DATA only):
  - The counter clears on every accepted byte and increments each clock.
  - When it reaches the limit, go to IDLE with no reply and no bus strobe.
- Discarded bytes: an rx_rdy in BUS_WR, BUS_RD, WAIT_RD, SEND or SEND_HOLD is discarded and sets overrun=1. overrun is cleared only by reset.
- A bus_rvalid outside WAIT_RD is ignored.
- Reset mid-operation: any in-flight strobe or ena_tx drops immediately, and no response is sent after release.
- Latency:
  - Last command byte to bus_we: 1 clock.
  - bus_we to ena_tx: 2 clocks, if tx_busy=0.
  - bus_rvalid to ena_tx: 1 clock, if tx_busy=0.

Decomposition:
- Shared package rs232_cmd_pkg holds:
  - opcode constants OP_WR=0x57, OP_RD=0x52;
  - response constants RSP_OK=0x4B, RSP_BADOP=0x3F, RSP_RDTO=0x21;
  - the state enum (IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, WAIT_RD, SEND, SEND_HOLD).
- One sub-module is natural: rs232_tx_handshake. It implements the SEND/SEND_HOLD request, guard and tx_busy wait behind a one-entry load/ready interface. It is reusable by other UART producers.

Test Plan:
- Write: bytes 0x57,0x10,0xA5 -> one bus_we pulse with bus_addr=0x10, bus_wdata=0xA5, then one ena_tx with tx_data=0x4B; overrun=0.
- Read: 0x52,0x22; bench returns bus_rvalid with bus_rdata=0x3C three clocks after bus_re -> one ena_tx with tx_data=0x3C. A read with no bus_rvalid -> tx_data=0x21 exactly RD_TIMEOUT_CLKS+1 clocks after bus_re.
- Bad opcode 0x00 -> tx_data=0x3F, no bus strobe. Following 0x52,0x01 is decoded normally.
- Timeout: 0x57,0x10 then a silence longer than the limit (use small BYTE_TIMEOUT_US), then 0x52,0x05 -> no bus_we; a read of 0x05 occurs and one reply is sent.
- Flow control: hold tx_busy=1 for 500 clocks while a reply is pending -> ena_tx stays 0, then asserts once the clock after tx_busy falls. An rx byte arriving during the wait sets overrun=1 and is dropped.
- Reset asserted during WAIT_RD and during SEND -> outputs go to 0 asynchronously and no ena_tx follows release.
